// File: rtl/bp_sac_pkg.sv
// Shared SAC definitions: DMA reader state encoding plus the memory-message
// types, widths and address helper used on the socket's I/O port.
package bp_sac_pkg;

    localparam int unsigned bp_sac_dma_dword_bytes_gp   = 8;
    localparam int unsigned bp_sac_paddr_width_gp       = 40;
    localparam int unsigned bp_sac_dword_width_gp       = 64;
    localparam int unsigned bp_sac_mem_payload_width_gp = 16;

    typedef enum logic [1:0] {
        e_dma_idle  = 2'd0,
        e_dma_run   = 2'd1,
        e_dma_drain = 2'd2
    } bp_sac_dma_state_e;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'b000,
        e_mem_msg_size_2  = 3'b001,
        e_mem_msg_size_4  = 3'b010,
        e_mem_msg_size_8  = 3'b011,
        e_mem_msg_size_16 = 3'b100,
        e_mem_msg_size_32 = 3'b101,
        e_mem_msg_size_64 = 3'b110
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [bp_sac_dword_width_gp-1:0]       data;
        logic [bp_sac_mem_payload_width_gp-1:0] payload;
        bp_mem_msg_size_e                       size;
        logic [bp_sac_paddr_width_gp-1:0]       addr;
        bp_cce_mem_cmd_type_e                   msg_type;
    } bp_cce_mem_msg_s;

    // Clear the byte-offset bits so the address lands on a dword boundary
    function automatic logic [bp_sac_paddr_width_gp-1:0] bp_sac_dword_align(
        input logic [bp_sac_paddr_width_gp-1:0] addr
    );
        return addr & ~bp_sac_paddr_width_gp'(bp_sac_dma_dword_bytes_gp - 1);
    endfunction

endpackage

// File: rtl/bp_sac_dma_reader_fifo.sv
// Small 1-read/1-write FIFO for the DMA response buffer; same behaviour as
// bsg_fifo_1r1w_small (registered storage, head visible while count != 0).
module bp_sac_dma_reader_fifo #(
    parameter int unsigned els_p   = 8,
    parameter int unsigned width_p = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       yumi_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(els_p):0]     count_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (v_i) begin
            wptr_d = wptr_q + ptr_width_lp'(1);
        end
        if (yumi_i) begin
            rptr_d = rptr_q + ptr_width_lp'(1);
        end
        case ({v_i, yumi_i})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; it is only read where count_q says it is valid
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    push_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        v_i |-> (count_q != cnt_width_lp'(els_p)));
    pop_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o);

endmodule

// File: rtl/bp_sac_dma_reader.sv
// SAC streaming read engine: issues uncached 8-byte reads under a credit limit
// and streams the in-order responses out. Define BP_SAC_DMA_STATS_EN for stats.
module bp_sac_dma_reader
    import bp_sac_pkg::*;
#(
    parameter int unsigned fifo_els_p  = 8,
    parameter int unsigned len_width_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic [bp_sac_paddr_width_gp-1:0] base_addr_i,
    input  logic [len_width_p-1:0]           len_i,
    output logic                             busy_o,
    output logic                             done_o,
    output bp_cce_mem_msg_s                  io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_yumi_i,
    input  bp_cce_mem_msg_s                  io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_ready_o,
    output logic [bp_sac_dword_width_gp-1:0] data_o,
    output logic                             data_v_o,
    input  logic                             data_ready_i,
    output logic [31:0]                      stat_cycles_o,
    output logic [31:0]                      stat_stalls_o
);

    localparam int unsigned paddr_width_lp  = bp_sac_paddr_width_gp;
    localparam int unsigned dword_width_lp  = bp_sac_dword_width_gp;
    localparam int unsigned cnt_width_lp    = $clog2(fifo_els_p) + 1;
    localparam int unsigned credit_width_lp = cnt_width_lp + 1;

    bp_sac_dma_state_e          state_q, state_d;
    logic [paddr_width_lp-1:0]  addr_q, addr_d;
    logic [len_width_p-1:0]     remaining_q, remaining_d;
    logic [cnt_width_lp-1:0]    outstanding_q, outstanding_d;
    logic                       done_q, done_d;

    logic                       cmd_fire;
    logic                       resp_fire;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [cnt_width_lp-1:0]    fifo_count;
    logic                       credit_ok;
    logic                       unused_resp;

    // Outstanding reads plus buffered dwords never exceed the buffer depth
    assign credit_ok = (credit_width_lp'(outstanding_q) + credit_width_lp'(fifo_count))
                       < credit_width_lp'(fifo_els_p);

    assign busy_o          = (state_q != e_dma_idle);
    assign done_o          = done_q;
    assign io_cmd_v_o      = (state_q == e_dma_run) && credit_ok;
    // Also ready in IDLE so responses left over from an abandoned transfer drain away
    assign io_resp_ready_o = (outstanding_q != '0) || (state_q == e_dma_idle);

    assign cmd_fire  = io_cmd_v_o && io_cmd_yumi_i;
    assign resp_fire = io_resp_v_i && io_resp_ready_o;
    assign fifo_push = resp_fire && (outstanding_q != '0);
    assign fifo_pop  = data_v_o && data_ready_i;

    assign unused_resp = ^{io_resp_i.addr, io_resp_i.size, io_resp_i.payload};

    always_comb begin
        io_cmd_o          = '0;
        io_cmd_o.msg_type = e_cce_mem_uc_rd;
        io_cmd_o.addr     = addr_q;
        io_cmd_o.size     = e_mem_msg_size_8;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        done_d        = 1'b0;

        case ({cmd_fire, fifo_push})
            2'b10:   outstanding_d = outstanding_q + cnt_width_lp'(1);
            2'b01:   outstanding_d = outstanding_q - cnt_width_lp'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            e_dma_idle: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = e_dma_run;
                        addr_d      = bp_sac_dword_align(base_addr_i);
                        remaining_d = len_i;
                    end
                end
            end
            e_dma_run: begin
                if (cmd_fire) begin
                    addr_d      = addr_q + paddr_width_lp'(bp_sac_dma_dword_bytes_gp);
                    remaining_d = remaining_q - len_width_p'(1);
                    if (remaining_q == len_width_p'(1)) begin
                        state_d = e_dma_drain;
                    end
                end
            end
            e_dma_drain: begin
                if ((outstanding_q == '0) &&
                    ((fifo_count == '0) ||
                     ((fifo_count == cnt_width_lp'(1)) && fifo_pop))) begin
                    state_d = e_dma_idle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = e_dma_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= e_dma_idle;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
        end
    end

    bp_sac_dma_reader_fifo #(
        .els_p   (fifo_els_p),
        .width_p (dword_width_lp)
    ) resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (fifo_push),
        .data_i    (io_resp_i.data),
        .yumi_i    (fifo_pop),
        .v_o       (data_v_o),
        .data_o    (data_o),
        .count_o   (fifo_count)
    );

`ifdef BP_SAC_DMA_STATS_EN
    logic [31:0] stat_cycles_q, stat_cycles_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;
    logic [32:0] stall_sum;
    logic        cmd_stall;
    logic        data_stall;

    assign cmd_stall  = (state_q == e_dma_run) && io_cmd_v_o && !io_cmd_yumi_i;
    assign data_stall = data_v_o && !data_ready_i;
    assign stall_sum  = 33'(stat_stalls_q) + 33'(cmd_stall) + 33'(data_stall);

    // Saturating counters, cleared when a new transfer begins
    always_comb begin
        stat_cycles_d = stat_cycles_q;
        stat_stalls_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
        if (busy_o && (stat_cycles_q != 32'hFFFF_FFFF)) begin
            stat_cycles_d = stat_cycles_q + 32'd1;
        end
        if ((state_q == e_dma_idle) && (state_d == e_dma_run)) begin
            stat_cycles_d = '0;
            stat_stalls_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stat_cycles_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_cycles_q <= stat_cycles_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_cycles_o = stat_cycles_q;
    assign stat_stalls_o = stat_stalls_q;
`else
    assign stat_cycles_o = '0;
    assign stat_stalls_o = '0;
`endif

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io_cmd_yumi_i |-> io_cmd_v_o);
    resp_not_uc_rd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fifo_push |-> (io_resp_i.msg_type == e_cce_mem_uc_rd));

endmodule

// File: doc/bp_sac_dma_reader.md
Name: bp_sac_dma_reader

Overview:
- Streaming read engine inside the SAC accelerator. It sits directly upstream of the socket's inbound I/O port (io_cmd_o/io_resp_i side).
- When software starts it, the block issues a sequence of uncached 8-byte read commands to memory through the socket.
- It collects the responses in order and presents the returned dwords as a valid/ready stream to the accelerator datapath.
- It tracks how many reads are outstanding, so response data never overflows its internal buffer.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor configuration; supplies paddr_width_p, dword_width_p and the bp_cce_mem_msg_s widths.
- fifo_els_p, 8: depth of the response-data buffer. Also the hard limit on outstanding reads. Power of two, ≥2.
- len_width_p, 16: width of the transfer length, counted in dwords.

Ports:
- clk_i  in  1  core clock.
- reset_n_i  in  1  synchronous reset, active-low.
- start_i  in  1  one-cycle start pulse. Ignored unless state is IDLE.
- base_addr_i  in  paddr_width_p  start byte address. Bits [2:0] are ignored and treated as zero.
- len_i  in  len_width_p  number of dwords to read.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse when the last dword leaves the stream.
- io_cmd_o  out  $bits(bp_cce_mem_msg_s)  uncached read command.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  socket consumed the command.
- io_resp_i  in  $bits(bp_cce_mem_msg_s)  read response.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  engine can accept a response.
- data_o  out  dword_width_p  streamed data.
- data_v_o  out  1  stream valid.
- data_ready_i  in  1  stream ready.
- stat_cycles_o  out  32  see Optional Feature.
- stat_stalls_o  out  32  see Optional Feature.

Behaviour:
- Reset (reset_n_i==0 at clk_i edge):
  - state=IDLE; all counters cleared; FIFO emptied.
  - busy_o, done_o, io_cmd_v_o, data_v_o and both stat outputs are 0.
  - Reset asserted mid-transfer abandons the transfer. Late responses arriving after reset are accepted and dropped for the current IDLE period only. The bench must not rely on this.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start_i with len_i≠0. Latch addr_r=base_addr_i & ~7 and remaining_r=len_i.
  - Start with len_i==0: stay IDLE and pulse done_o on the next cycle.
  - RUN→DRAIN on the cycle the last command is yumi'd (remaining_r reaches 0).
  - DRAIN→IDLE when outstanding_r==0, FIFO is empty, and the final dword has been handshaken. done_o pulses that same cycle.
  - start_i in RUN or DRAIN is ignored.
- Command fields:
  - msg_type=e_cce_mem_uc_rd, addr=addr_r, size=e_mem_msg_size_8, payload=0, data=0.
- Issue rule:
  - io_cmd_v_o=(state==RUN) && (outstanding_r + fifo_count < fifo_els_p). This is a credit scheme; the FIFO never overflows.
  - io_cmd_o depends only on registers (no combinational path from inputs).
  - On yumi: addr_r+=8 (wraps modulo 2^paddr_width_p), remaining_r-=1, outstanding_r+=1.
  - io_cmd_yumi_i while io_cmd_v_o==0 is illegal (assertion).
- Response rule:
  - io_resp_ready_o=1 whenever outstanding_r≠0. It is guaranteed by credit.
  - On accept: push io_resp_i.data[dword_width_p-1:0] into the FIFO; outstanding_r-=1.
  - Responses are in order; no reordering.
  - Response with msg_type≠e_cce_mem_uc_rd: assertion, data still pushed.
- Simultaneous cmd yumi and resp accept: outstanding_r is unchanged.
- Stream: data_o/data_v_o come from the FIFO head, standard valid/ready. Data is held stable while not ready.
- Latency:
  - First io_cmd_v_o one cycle after start_i.
  - Response to data_v_o is one cycle (registered FIFO).
  - Sustained throughput is 1 dword/cycle when the socket and consumer never stall.

Optional Feature:
- Macro BP_SAC_DMA_STATS_EN.
- Defined:
  - stat_cycles_o counts cycles with busy_o=1.
  - stat_stalls_o counts cycles in RUN with io_cmd_v_o=1 and io_cmd_yumi_i=0, plus cycles with data_v_o=1 and data_ready_i=0.
  - Both clear on the IDLE→RUN transition and saturate at 2^32-1.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package bp_sac_pkg (new):
  - State enum bp_sac_dma_state_e {e_dma_idle, e_dma_run, e_dma_drain}.
  - Localparam bp_sac_dma_dword_bytes_gp=8.
- Message types come from bp_me_pkg.
- One sub-module: the existing bsg_fifo_1r1w_small (els_p=fifo_els_p, width_p=dword_width_p) for the response buffer. The credit counter and FSM stay in the top module.

Test Plan:
1. base=0x8000_0000, len=4, socket yumi and resp same cycle, data_ready_i=1 → four commands at addresses 0x8000_0000/08/10/18 on consecutive cycles; data_o is the 4 response dwords in order; done_o pulses once; busy_o falls the same cycle.
2. len=0 start → no io_cmd_v_o; done_o pulses 1 cycle after start; busy_o stays 0.
3. len=20, fifo_els_p=8, data_ready_i=0 throughout, responses immediate → exactly 8 commands issued, then io_cmd_v_o=0 indefinitely; releasing data_ready_i completes all 20 in order.
4. base=0xFF_FFFF_FFF8 (paddr 40), len=2 → second address 0x00_0000_0000 (wrap).
5. start_i pulsed during RUN with different base/len → ignored; original transfer completes unchanged.
6. Reset asserted after 3 of 6 commands → all outputs 0 the next cycle; a new start with len=2 completes with exactly 2 dwords delivered.
7. With BP_SAC_DMA_STATS_EN, len=4, consumer stalls 5 cycles → stat_stalls_o=5 and stat_cycles_o equals the busy_o-high count. Without the macro, both read 0.
